// File: rtl/aes_mode_ctrl.sv
// Block-cipher mode controller (ECB/CBC/CTR) that sequences one AES core engine
// over a valid/ready 128-bit stream, with an input FIFO and a single output register.
module aes_mode_ctrl #(
    parameter int IN_DEPTH  = 4,
    parameter int CTR_WIDTH = 32
) (
    input  logic         ICLK,
    input  logic         IRST,
    input  logic [1:0]   IMODE,
    input  logic         IENCDEC,
    input  logic [255:0] IKEY,
    input  logic         IKEYLEN,
    input  logic [127:0] IIV,
    input  logic         ISTART,
    output logic         OBUSY,
    output logic         OKEY_READY,
    input  logic         IDATA_VALID,
    output logic         ODATA_READY,
    input  logic [127:0] IDATA,
    output logic         ORESULT_VALID,
    input  logic         IRESULT_READY,
    output logic [127:0] ORESULT,
    output logic         OCORE_ENCDEC,
    output logic         OCORE_INIT,
    output logic         OCORE_NEXT,
    output logic [255:0] OCORE_KEY,
    output logic         OCORE_KEYLEN,
    output logic [127:0] OCORE_BLOCK,
    input  logic         ICORE_READY,
    input  logic [127:0] ICORE_RESULT
);

    localparam int PTR_W = $clog2(IN_DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = 1;
    // A shift by 128 yields zero, so CTR_WIDTH=128 still produces an all-ones mask.
    localparam logic [127:0] CTR_MASK = (128'd1 << CTR_WIDTH) - 128'd1;

    typedef enum logic [2:0] {S_IDLE, S_KINIT, S_RDY, S_ISSUE, S_WAIT, S_OUT} state_t;
    typedef enum logic [1:0] {M_ECB, M_CBC, M_CTR} mode_t;

    state_t         state;
    mode_t          mode;
    logic           encdec;
    logic [127:0]   chain;
    logic [127:0]   hold;
    logic [1:0]     wait_cnt;

    logic [127:0]   mem [IN_DEPTH];
    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;

    logic           fifo_empty;
    logic           fifo_full;
    logic           push;
    logic           pop;
    logic           start_ok;
    logic           done;
    logic [127:0]   head;
    logic [127:0]   ctr_inc;
    logic [127:0]   core_block_d;
    logic [127:0]   result_d;
    logic [127:0]   chain_d;

    assign fifo_empty  = (wr_ptr == rd_ptr);
    assign fifo_full   = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                         (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign ODATA_READY = (state != S_IDLE) && !fifo_full;
    assign push        = IDATA_VALID && ODATA_READY;
    assign pop         = (state == S_RDY) && !fifo_empty;
    assign head        = mem[rd_ptr[PTR_W-1:0]];

    assign OBUSY = (state == S_KINIT) || (state == S_ISSUE) || (state == S_WAIT) ||
                   !fifo_empty || ORESULT_VALID;
    // OBUSY=0 already implies IDLE or RDY with an empty FIFO.
    assign start_ok = ISTART && !OBUSY;

    // The core's ready is only trusted from the second cycle after an INIT/NEXT pulse.
    assign done = (wait_cnt == 2'd2) && ICORE_READY;

    assign ctr_inc = (chain & ~CTR_MASK) | ((chain + 128'd1) & CTR_MASK);

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        core_block_d = head;
        result_d     = ICORE_RESULT;
        chain_d      = chain;
        case (mode)
            M_CBC: begin
                core_block_d = encdec ? (head ^ chain) : head;
                result_d     = encdec ? ICORE_RESULT : (ICORE_RESULT ^ chain);
                chain_d      = encdec ? ICORE_RESULT : hold;
            end
            M_CTR: begin
                core_block_d = chain;
                result_d     = ICORE_RESULT ^ hold;
                chain_d      = ctr_inc;
            end
            default: ;
        endcase
    end

    // NOTE: the FIFO storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge ICLK) begin
        if (push) begin
            mem[wr_ptr[PTR_W-1:0]] <= IDATA;
        end
    end

    always_ff @(posedge ICLK or posedge IRST) begin
        if (IRST) begin
            state         <= S_IDLE;
            mode          <= M_ECB;
            encdec        <= 1'b0;
            chain         <= '0;
            hold          <= '0;
            wait_cnt      <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            OKEY_READY    <= 1'b0;
            ORESULT_VALID <= 1'b0;
            ORESULT       <= '0;
            OCORE_ENCDEC  <= 1'b0;
            OCORE_INIT    <= 1'b0;
            OCORE_NEXT    <= 1'b0;
            OCORE_KEY     <= '0;
            OCORE_KEYLEN  <= 1'b0;
            OCORE_BLOCK   <= '0;
        end else begin
            OCORE_INIT <= 1'b0;
            OCORE_NEXT <= 1'b0;
            if (wait_cnt != 2'd2) begin
                wait_cnt <= wait_cnt + 2'd1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end

            case (state)
                S_IDLE, S_RDY: begin
                    if (start_ok) begin
                        case (IMODE)
                            2'd1:    mode <= M_CBC;
                            2'd2:    mode <= M_CTR;
                            default: mode <= M_ECB;
                        endcase
                        encdec       <= IENCDEC;
                        OCORE_ENCDEC <= (IMODE == 2'd2) ? 1'b1 : IENCDEC;
                        OCORE_KEY    <= IKEY;
                        OCORE_KEYLEN <= IKEYLEN;
                        chain        <= IIV;
                        OKEY_READY   <= 1'b0;
                        OCORE_INIT   <= 1'b1;
                        wait_cnt     <= 2'd0;
                        state        <= S_KINIT;
                    end else if (pop) begin
                        OCORE_BLOCK <= core_block_d;
                        hold        <= head;
                        state       <= S_ISSUE;
                    end
                end
                S_KINIT: begin
                    if (done) begin
                        OKEY_READY <= 1'b1;
                        state      <= S_RDY;
                    end
                end
                S_ISSUE: begin
                    OCORE_NEXT <= 1'b1;
                    wait_cnt   <= 2'd0;
                    state      <= S_WAIT;
                end
                S_WAIT: begin
                    if (done) begin
                        ORESULT       <= result_d;
                        chain         <= chain_d;
                        ORESULT_VALID <= 1'b1;
                        state         <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (IRESULT_READY) begin
                        ORESULT_VALID <= 1'b0;
                        state         <= S_RDY;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_mode_ctrl.sv
// Directed bench for aes_mode_ctrl using a reversible stand-in core (rotate + key xor)
// with fixed latency; mode chaining is checked against an independent reference model.
module tb_aes_mode_ctrl;

    localparam int IN_DEPTH  = 4;
    localparam int CTR_WIDTH = 8;
    localparam int LAT       = 3;

    logic         ICLK;
    logic         IRST;
    logic [1:0]   IMODE;
    logic         IENCDEC;
    logic [255:0] IKEY;
    logic         IKEYLEN;
    logic [127:0] IIV;
    logic         ISTART;
    logic         OBUSY;
    logic         OKEY_READY;
    logic         IDATA_VALID;
    logic         ODATA_READY;
    logic [127:0] IDATA;
    logic         ORESULT_VALID;
    logic         IRESULT_READY;
    logic [127:0] ORESULT;
    logic         OCORE_ENCDEC;
    logic         OCORE_INIT;
    logic         OCORE_NEXT;
    logic [255:0] OCORE_KEY;
    logic         OCORE_KEYLEN;
    logic [127:0] OCORE_BLOCK;
    logic         ICORE_READY;
    logic [127:0] ICORE_RESULT;

    aes_mode_ctrl #(.IN_DEPTH(IN_DEPTH), .CTR_WIDTH(CTR_WIDTH)) dut (
        .ICLK(ICLK), .IRST(IRST), .IMODE(IMODE), .IENCDEC(IENCDEC), .IKEY(IKEY),
        .IKEYLEN(IKEYLEN), .IIV(IIV), .ISTART(ISTART), .OBUSY(OBUSY),
        .OKEY_READY(OKEY_READY), .IDATA_VALID(IDATA_VALID), .ODATA_READY(ODATA_READY),
        .IDATA(IDATA), .ORESULT_VALID(ORESULT_VALID), .IRESULT_READY(IRESULT_READY),
        .ORESULT(ORESULT), .OCORE_ENCDEC(OCORE_ENCDEC), .OCORE_INIT(OCORE_INIT),
        .OCORE_NEXT(OCORE_NEXT), .OCORE_KEY(OCORE_KEY), .OCORE_KEYLEN(OCORE_KEYLEN),
        .OCORE_BLOCK(OCORE_BLOCK), .ICORE_READY(ICORE_READY), .ICORE_RESULT(ICORE_RESULT)
    );

    initial ICLK = 1'b0;
    always #5 ICLK = ~ICLK;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Stand-in cipher: encrypt = rotl8 then xor key; decrypt is its inverse.
    function automatic logic [127:0] kk_of(input logic [255:0] k, input logic kl);
        return k[255:128] ^ (kl ? k[127:0] : 128'h0);
    endfunction

    function automatic logic [127:0] toy_enc(input logic [127:0] k, input logic [127:0] x);
        return {x[119:0], x[127:120]} ^ k;
    endfunction

    function automatic logic [127:0] toy_dec(input logic [127:0] k, input logic [127:0] y);
        logic [127:0] t;
        t = y ^ k;
        return {t[7:0], t[127:8]};
    endfunction

    // Core model: reacts on falling edges so DUT outputs are settled.
    int           core_cnt = 0;
    logic         core_is_next = 1'b0;
    logic [127:0] core_blk;
    logic         core_enc;
    logic [127:0] next_blocks [$];

    initial begin
        ICORE_READY  = 1'b1;
        ICORE_RESULT = '0;
    end

    always @(negedge ICLK) begin
        if (IRST) begin
            ICORE_READY = 1'b1;
            core_cnt    = 0;
        end else if (OCORE_INIT || OCORE_NEXT) begin
            ICORE_READY  = 1'b0;
            core_cnt     = LAT;
            core_is_next = OCORE_NEXT;
            if (OCORE_NEXT) begin
                core_blk = OCORE_BLOCK;
                core_enc = OCORE_ENCDEC;
                next_blocks.push_back(OCORE_BLOCK);
            end
        end else if (core_cnt > 0) begin
            core_cnt--;
            if (core_cnt == 0) begin
                ICORE_READY = 1'b1;
                if (core_is_next) begin
                    ICORE_RESULT = core_enc ? toy_enc(kk_of(OCORE_KEY, OCORE_KEYLEN), core_blk)
                                            : toy_dec(kk_of(OCORE_KEY, OCORE_KEYLEN), core_blk);
                end
            end
        end
    end

    // Reference mode model (CTR_WIDTH fixed at 8 for this bench).
    logic [1:0]   m_mode;
    logic         m_enc;
    logic [127:0] m_kk;
    logic [127:0] m_chain;

    task automatic model_start(input logic [1:0] mode, input logic enc, input logic [255:0] key,
                               input logic kl, input logic [127:0] iv);
        m_mode  = mode;
        m_enc   = enc;
        m_kk    = kk_of(key, kl);
        m_chain = iv;
    endtask

    task automatic model_step(input logic [127:0] d, output logic [127:0] r);
        case (m_mode)
            2'd1: begin
                if (m_enc) begin
                    r       = toy_enc(m_kk, d ^ m_chain);
                    m_chain = r;
                end else begin
                    r       = toy_dec(m_kk, d) ^ m_chain;
                    m_chain = d;
                end
            end
            2'd2: begin
                r       = toy_enc(m_kk, m_chain) ^ d;
                m_chain = {m_chain[127:8], m_chain[7:0] + 8'd1};
            end
            default: r = m_enc ? toy_enc(m_kk, d) : toy_dec(m_kk, d);
        endcase
    endtask

    task automatic do_start(input logic [1:0] mode, input logic enc, input logic [255:0] key,
                            input logic kl, input logic [127:0] iv);
        int n;
        n = 0;
        while (OBUSY && n < 100) begin
            @(negedge ICLK);
            n++;
        end
        if (n == 100) check("start_wait_idle", 1'b0, 1'b1);
        IMODE   = mode;
        IENCDEC = enc;
        IKEY    = key;
        IKEYLEN = kl;
        IIV     = iv;
        ISTART  = 1'b1;
        next_blocks.delete();
        model_start(mode, enc, key, kl, iv);
        @(negedge ICLK);
        ISTART = 1'b0;
        check("init_pulse", OCORE_INIT, 1'b1);
        n = 0;
        while (!OKEY_READY && n < 20) begin
            @(negedge ICLK);
            n++;
        end
        if (n == 20) check("key_init_timeout", OKEY_READY, 1'b1);
    endtask

    task automatic push(input logic [127:0] d);
        int n;
        IDATA       = d;
        IDATA_VALID = 1'b1;
        n = 0;
        while (!ODATA_READY && n < 50) begin
            @(negedge ICLK);
            n++;
        end
        if (n == 50) check("push_timeout", ODATA_READY, 1'b1);
        @(negedge ICLK);
        IDATA_VALID = 1'b0;
    endtask

    task automatic get_check(input string name, input logic [127:0] exp);
        int n;
        IRESULT_READY = 1'b1;
        n = 0;
        while (!ORESULT_VALID && n < 50) begin
            @(negedge ICLK);
            n++;
        end
        if (n == 50) check({name, "_timeout"}, ORESULT_VALID, 1'b1);
        else check(name, ORESULT, exp);
        @(negedge ICLK);
        IRESULT_READY = 1'b0;
    endtask

    function automatic logic [7:0] ctrl_outs();
        return {OBUSY, OKEY_READY, ODATA_READY, ORESULT_VALID,
                OCORE_INIT, OCORE_NEXT, OCORE_ENCDEC, OCORE_KEYLEN};
    endfunction

    typedef struct {
        bit           start;
        logic [1:0]   mode;
        logic         enc;
        logic [255:0] key;
        logic         kl;
        logic [127:0] iv;
        logic [127:0] data;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs [15];

    localparam logic [255:0] K1  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] K2  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K3  = {128'h000102030405060708090a0b0c0d0e0f,
                                    128'h101112131415161718191a1b1c1d1e1f};
    localparam logic [127:0] IV0 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] IVC = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    localparam logic [127:0] P0  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] P1  = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] P2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] P3  = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
    localparam logic [127:0] P4  = 128'hf69f2445df4f9b17ad2b417be66c3710;

    task automatic set_vec(input int i, input bit st, input logic [1:0] mode, input logic enc,
                           input logic [255:0] key, input logic kl, input logic [127:0] iv,
                           input logic [127:0] d);
        vecs[i].start = st;
        vecs[i].mode  = mode;
        vecs[i].enc   = enc;
        vecs[i].key   = key;
        vecs[i].kl    = kl;
        vecs[i].iv    = iv;
        vecs[i].data  = d;
        vecs[i].exp   = '0;
    endtask

    logic [127:0] bp_data [6];
    logic [127:0] bp_held;
    logic [127:0] exp_r;
    bit           bp_seen;
    bit           bp_unstable;
    int           acc;
    int           n;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        IRST = 1'b1; IMODE = '0; IENCDEC = 1'b0; IKEY = '0; IKEYLEN = 1'b0; IIV = '0;
        ISTART = 1'b0; IDATA_VALID = 1'b0; IDATA = '0; IRESULT_READY = 1'b0;

        // Vector table; row 0 is hand-computed: rotl8(P0) ^ key.
        set_vec(0, 1, 2'd0, 1'b1, K1, 1'b0, '0, P0);
        set_vec(1, 1, 2'd3, 1'b0, K1, 1'b0, '0, '0);
        set_vec(2, 1, 2'd1, 1'b1, K2, 1'b0, IV0, P1);
        set_vec(3, 0, 2'd1, 1'b1, K2, 1'b0, IV0, P2);
        set_vec(4, 0, 2'd1, 1'b1, K2, 1'b0, IV0, P3);
        set_vec(5, 0, 2'd1, 1'b1, K2, 1'b0, IV0, P4);
        set_vec(6, 1, 2'd1, 1'b0, K2, 1'b0, IV0, '0);
        set_vec(7, 0, 2'd1, 1'b0, K2, 1'b0, IV0, '0);
        set_vec(8, 0, 2'd1, 1'b0, K2, 1'b0, IV0, '0);
        set_vec(9, 0, 2'd1, 1'b0, K2, 1'b0, IV0, '0);
        set_vec(10, 1, 2'd2, 1'b0, K2, 1'b0, IVC, P1);
        set_vec(11, 0, 2'd2, 1'b0, K2, 1'b0, IVC, P2);
        set_vec(12, 0, 2'd2, 1'b0, K2, 1'b0, IVC, P3);
        set_vec(13, 0, 2'd2, 1'b0, K2, 1'b0, IVC, P4);
        set_vec(14, 1, 2'd0, 1'b1, K3, 1'b1, '0, P1);
        vecs[0].exp = 128'h112331475163718f91a3b1c7d1e3f10f;
        for (int i = 1; i < 15; i++) begin
            if (i == 1) vecs[1].data = vecs[0].exp;
            if (i >= 6 && i <= 9) vecs[i].data = vecs[i-4].exp;
            if (vecs[i].start) model_start(vecs[i].mode, vecs[i].enc, vecs[i].key, vecs[i].kl, vecs[i].iv);
            model_step(vecs[i].data, vecs[i].exp);
        end

        // Reset state
        repeat (3) @(negedge ICLK);
        check("reset_ctrl", ctrl_outs(), 8'h0);
        check("reset_result", ORESULT, '0);
        check("reset_block", OCORE_BLOCK, '0);
        check("reset_key", OCORE_KEY, '0);
        IRST = 1'b0;
        @(negedge ICLK);
        check("idle_ready", ODATA_READY, 1'b0);

        for (int i = 0; i < 15; i++) begin
            if (vecs[i].start) begin
                do_start(vecs[i].mode, vecs[i].enc, vecs[i].key, vecs[i].kl, vecs[i].iv);
                check($sformatf("encdec_%0d", i), OCORE_ENCDEC,
                      (vecs[i].mode == 2'd2) ? 1'b1 : vecs[i].enc);
                check($sformatf("corekey_%0d", i), OCORE_KEY, vecs[i].key);
                check($sformatf("keylen_%0d", i), OCORE_KEYLEN, vecs[i].kl);
            end
            push(vecs[i].data);
            get_check($sformatf("vec_%0d", i), vecs[i].exp);
            if (i == 11) begin
                check("ctr_first_counter", next_blocks[0], IVC);
                check("ctr_wrap_counter", next_blocks[1], 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfe00);
            end
        end

        // Backpressure: output stalled, push IN_DEPTH+2 blocks, bogus ISTART while busy.
        do_start(2'd0, 1'b1, K1, 1'b0, '0);
        for (int i = 0; i < 6; i++) bp_data[i] = {4{32'h1000_0000 + i * 32'h0101_0101}};
        acc = 0; bp_seen = 0; bp_unstable = 0;
        for (int cyc = 0; cyc < 50; cyc++) begin
            @(negedge ICLK);
            IDATA_VALID = (acc < 6);
            if (acc < 6) IDATA = bp_data[acc];
            ISTART = (cyc == 25);
            if (cyc == 25) begin
                IMODE = 2'd1; IENCDEC = 1'b0; IKEY = K2; IIV = '1;
            end
            if (cyc == 26) begin
                check("busy_start_init", OCORE_INIT, 1'b0);
                check("busy_start_key", OCORE_KEY, K1);
                check("busy_start_encdec", OCORE_ENCDEC, 1'b1);
                check("busy_start_keyready", OKEY_READY, 1'b1);
            end
            if (ORESULT_VALID) begin
                if (!bp_seen) begin
                    bp_held = ORESULT;
                    bp_seen = 1;
                end else if (ORESULT !== bp_held) begin
                    bp_unstable = 1;
                end
            end
            if (IDATA_VALID && ODATA_READY) acc++;
        end
        @(negedge ICLK);
        IDATA_VALID = 1'b0;
        check("bp_accepted", acc, IN_DEPTH + 1);
        check("bp_ready_low", ODATA_READY, 1'b0);
        check("bp_result_stable", bp_unstable, 1'b0);
        check("bp_busy", OBUSY, 1'b1);
        for (int i = 0; i < 5; i++) begin
            model_step(bp_data[i], exp_r);
            get_check($sformatf("bp_out_%0d", i), exp_r);
        end
        push(bp_data[5]);
        model_step(bp_data[5], exp_r);
        get_check("bp_out_5", exp_r);

        // Reset while the core operation is in flight.
        push(P2);
        n = 0;
        while (!OCORE_NEXT && n < 20) begin
            @(negedge ICLK);
            n++;
        end
        if (n == 20) check("next_timeout", OCORE_NEXT, 1'b1);
        @(negedge ICLK);
        IRST = 1'b1;
        #1;
        check("midop_reset_ctrl", ctrl_outs(), 8'h0);
        check("midop_reset_result", ORESULT, '0);
        check("midop_reset_block", OCORE_BLOCK, '0);
        check("midop_reset_key", OCORE_KEY, '0);
        @(negedge ICLK);
        @(negedge ICLK);
        IRST = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge ICLK);
            check($sformatf("post_reset_%0d", i), {OKEY_READY, ODATA_READY, ORESULT_VALID}, 3'b000);
        end
        do_start(2'd0, 1'b0, K2, 1'b0, '0);
        check("rekey_ready", OKEY_READY, 1'b1);
        push(P3);
        model_step(P3, exp_r);
        get_check("after_reset_ecb", exp_r);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
